fir_core: RTL and testbench

- Filter engine between the input sample RAM and the output result RAM; the AXI slave fills the first and drains the second.
- On a start pulse, computes y[n] = sum over k=0..TAPS-1 of h[k]*x[n-k] for n = 0..count-1, where x[n-k] with n-k<0 is treated as 0.
- Reads signed 16-bit samples and coefficients, accumulates full precision, and writes saturated 21-bit results at the same index n.

---
 rtl/fir_pkg.sv | 35 +++
 rtl/fir_mac.sv | 54 +++++
 rtl/fir_core.sv | 151 +++++++++++++++
 tb/tb_fir_core.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR filter engine: FSM state encoding,
// accumulator sizing and the shift-and-saturate used on each result.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MAC    = 3'd1,
        DRAIN  = 3'd2,
        WRITE  = 3'd3,
        FINISH = 3'd4
    } fir_state_t;

    function automatic int acc_width(input int data_size, input int taps);
        return 2 * data_size + $clog2(taps);
    endfunction

    // Result is returned sign-extended to 64 bits; the caller keeps the low res_bits.
    function automatic logic signed [63:0] sat_res(input logic signed [63:0] acc,
                                                    input int shift,
                                                    input int res_bits = 21);
        logic signed [63:0] w_shifted;
        logic signed [63:0] w_max;
        logic signed [63:0] w_min;
        w_shifted = acc >>> shift;
        w_max     = (64'sd1 <<< (res_bits - 1)) - 64'sd1;
        w_min     = -(64'sd1 <<< (res_bits - 1));
        if (w_shifted > w_max) begin
            return w_max;
        end else if (w_shifted < w_min) begin
            return w_min;
        end
        return w_shifted;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Multiply-accumulate datapath: registered product, then accumulator with
// clear-on-first-tap; masked taps contribute zero. Two cycles input to accumulator.
module fir_mac
    import fir_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int TAPS      = 32,
    parameter int RES_SIZE  = 21,
    parameter int OUT_SHIFT = 15
) (
    input  logic                 a_clk,
    input  logic                 a_rst_n,
    input  logic                 i_en,
    input  logic                 i_first,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] i_sample,
    input  logic [DATA_SIZE-1:0] i_coef,
    output logic [RES_SIZE-1:0]  o_res
);

    localparam int PROD_W = 2 * DATA_SIZE;
    localparam int ACC_W  = acc_width(DATA_SIZE, TAPS);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [63:0]       w_acc_ext;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_en;
    logic                     r_first;
    logic signed [ACC_W-1:0]  r_acc;

    assign w_prod     = $signed(i_sample) * $signed(i_coef);
    assign w_prod_ext = {{(ACC_W - PROD_W){r_prod[PROD_W-1]}}, r_prod};
    assign w_acc_ext  = {{(64 - ACC_W){r_acc[ACC_W-1]}}, r_acc};

    always_ff @(posedge a_clk) begin
        if (!a_rst_n) begin
            r_prod  <= '0;
            r_en    <= 1'b0;
            r_first <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_en    <= i_en;
            r_first <= i_first;
            r_prod  <= (i_en && i_valid) ? w_prod : '0;
            if (r_en) begin
                r_acc <= r_first ? w_prod_ext : r_acc + w_prod_ext;
            end
        end
    end

    assign o_res = RES_SIZE'(sat_res(w_acc_ext, OUT_SHIFT, RES_SIZE));

endmodule

// File: rtl/fir_core.sv
// FIR engine: walks n over the requested outputs and k over the taps, reading
// sample/coef RAMs, and writes one saturated result per output index.
module fir_core
    import fir_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int ADDR_SIZE = 13,
    parameter int RES_SIZE  = 21,
    parameter int TAPS      = 32,
    parameter int OUT_SHIFT = 15
) (
    input  logic                     a_clk,
    input  logic                     a_rst_n,
    input  logic                     start,
    input  logic [ADDR_SIZE:0]       sample_count,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_SIZE-1:0]     f_address_rd,
    input  logic [DATA_SIZE-1:0]     f_sample,
    output logic [$clog2(TAPS)-1:0]  f_coef_addr,
    input  logic [DATA_SIZE-1:0]     f_coef,
    output logic [ADDR_SIZE-1:0]     f_address_wr,
    output logic [RES_SIZE-1:0]      f_data_out,
    output logic                     f_wr,
    output logic [2:0]               o_dbg_state
);

    localparam int                 K_W     = $clog2(TAPS);
    localparam logic [K_W-1:0]     K_LAST  = K_W'(TAPS - 1);
    localparam logic [K_W-1:0]     K_ONE   = K_W'(1);
    localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE + 1)'(1);
    localparam logic [ADDR_SIZE-1:0] N_ONE = ADDR_SIZE'(1);

    fir_state_t             r_state;
    fir_state_t             w_next;
    logic [ADDR_SIZE:0]     r_count;
    logic [ADDR_SIZE-1:0]   r_n;
    logic [K_W-1:0]         r_k;
    logic [1:0]             r_drain;
    logic                   r_en1;
    logic                   r_first1;
    logic                   r_vld1;
    logic                   r_wr;
    logic [ADDR_SIZE-1:0]   r_addr_wr;
    logic [RES_SIZE-1:0]    r_data_out;
    logic [ADDR_SIZE-1:0]   w_k_ext;
    logic                   w_valid;
    logic                   w_last;
    logic [RES_SIZE-1:0]    w_res;

    assign w_k_ext = {{(ADDR_SIZE - K_W){1'b0}}, r_k};
    assign w_valid = (r_n >= w_k_ext);
    assign w_last  = ({1'b0, r_n} == (r_count - CNT_ONE));

    // An empty run spends one DRAIN cycle so that done lands two cycles after start.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = (sample_count == '0) ? DRAIN : MAC;
            MAC:     if (r_k == K_LAST) w_next = DRAIN;
            DRAIN: begin
                if (r_count == '0)        w_next = FINISH;
                else if (r_drain == 2'd2) w_next = WRITE;
            end
            WRITE:   w_next = w_last ? FINISH : MAC;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge a_clk) begin
        if (!a_rst_n) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_drain    <= '0;
            r_en1      <= 1'b0;
            r_first1   <= 1'b0;
            r_vld1     <= 1'b0;
            r_wr       <= 1'b0;
            r_addr_wr  <= '0;
            r_data_out <= '0;
        end else begin
            r_state  <= w_next;
            r_en1    <= (r_state == MAC);
            r_first1 <= (r_k == '0);
            r_vld1   <= w_valid;
            case (r_state)
                IDLE: if (start) begin
                    r_count <= sample_count;
                    r_n     <= '0;
                    r_k     <= '0;
                    r_drain <= '0;
                end
                MAC:   r_k <= r_k + K_ONE;
                DRAIN: r_drain <= r_drain + 2'd1;
                WRITE: begin
                    r_drain <= '0;
                    if (!w_last) r_n <= r_n + N_ONE;
                end
                default: ;
            endcase
            // Result is captured on entry to WRITE, when the last tap has just landed.
            r_wr <= (w_next == WRITE);
            if (w_next == WRITE) begin
                r_addr_wr  <= r_n;
                r_data_out <= w_res;
            end
        end
    end

    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        f_coef_addr  = '0;
        f_address_rd = '0;
        case (r_state)
            MAC: begin
                busy         = 1'b1;
                f_coef_addr  = r_k;
                f_address_rd = r_n - w_k_ext;
            end
            DRAIN, WRITE: busy = 1'b1;
            FINISH:       done = 1'b1;
            default: ;
        endcase
    end

    assign f_wr         = r_wr;
    assign f_address_wr = r_addr_wr;
    assign f_data_out   = r_data_out;
    assign o_dbg_state  = r_state;

    fir_mac #(
        .DATA_SIZE(DATA_SIZE),
        .TAPS     (TAPS),
        .RES_SIZE (RES_SIZE),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_mac (
        .a_clk   (a_clk),
        .a_rst_n (a_rst_n),
        .i_en    (r_en1),
        .i_first (r_first1),
        .i_valid (r_vld1),
        .i_sample(f_sample),
        .i_coef  (f_coef),
        .o_res   (w_res)
    );

endmodule

// File: tb/tb_fir_core.sv
// Directed bench for fir_core: a 4-tap unshifted instance and a default instance,
// each with its own sample/coef memories, checked against hand-computed results.
module tb_fir_core;
    import fir_pkg::*;

    localparam int AW = 13;

    logic a_clk = 1'b0;
    always #5 a_clk = ~a_clk;

    logic          a_rst_n;
    logic          start4, start32;
    logic [AW:0]   s_count;

    logic          d4_busy, d4_done, d4_wr;
    logic [AW-1:0] d4_rd, d4_wa;
    logic [1:0]    d4_ca;
    logic [15:0]   d4_samp, d4_coef;
    logic [20:0]   d4_dout;
    logic [2:0]    d4_st;

    logic          d32_busy, d32_done, d32_wr;
    logic [AW-1:0] d32_rd, d32_wa;
    logic [4:0]    d32_ca;
    logic [15:0]   d32_samp, d32_coef;
    logic [20:0]   d32_dout;
    logic [2:0]    d32_st;

    logic [15:0] x4  [0:8191];
    logic [15:0] h4  [0:3];
    logic [15:0] x32 [0:8191];
    logic [15:0] h32 [0:31];

    always @(posedge a_clk) begin
        d4_samp  <= x4[d4_rd];
        d4_coef  <= h4[d4_ca];
        d32_samp <= x32[d32_rd];
        d32_coef <= h32[d32_ca];
    end

    fir_core #(.TAPS(4), .OUT_SHIFT(0)) u_dut4 (
        .a_clk(a_clk), .a_rst_n(a_rst_n), .start(start4), .sample_count(s_count),
        .busy(d4_busy), .done(d4_done), .f_address_rd(d4_rd), .f_sample(d4_samp),
        .f_coef_addr(d4_ca), .f_coef(d4_coef), .f_address_wr(d4_wa),
        .f_data_out(d4_dout), .f_wr(d4_wr), .o_dbg_state(d4_st)
    );

    fir_core u_dut32 (
        .a_clk(a_clk), .a_rst_n(a_rst_n), .start(start32), .sample_count(s_count),
        .busy(d32_busy), .done(d32_done), .f_address_rd(d32_rd), .f_sample(d32_samp),
        .f_coef_addr(d32_ca), .f_coef(d32_coef), .f_address_wr(d32_wa),
        .f_data_out(d32_dout), .f_wr(d32_wr), .o_dbg_state(d32_st)
    );

    logic          sel;
    logic          m_busy, m_done, m_wr;
    logic [AW-1:0] m_wa;
    logic [20:0]   m_dout;
    assign m_busy = sel ? d32_busy : d4_busy;
    assign m_done = sel ? d32_done : d4_done;
    assign m_wr   = sel ? d32_wr   : d4_wr;
    assign m_wa   = sel ? d32_wa   : d4_wa;
    assign m_dout = sel ? d32_dout : d4_dout;

    logic [20:0]   exp_q[$];
    logic [20:0]   got_d[$];
    logic [AW-1:0] got_a[$];
    int n_vec = 0;
    int n_err = 0;
    int done_cyc, first_wr, busy1, busy_done, extra_wr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run(input bit use32, input int cnt, input bit hold);
        int cyc;
        got_a.delete();
        got_d.delete();
        sel = use32;
        @(negedge a_clk);
        s_count = cnt[AW:0];
        if (use32) start32 = 1'b1; else start4 = 1'b1;
        @(posedge a_clk);
        @(negedge a_clk);
        if (!hold) begin start4 = 1'b0; start32 = 1'b0; end
        cyc = 1; done_cyc = -1; first_wr = -1; busy1 = m_busy; busy_done = -1;
        while (cyc < 2000) begin
            if (m_wr) begin
                got_a.push_back(m_wa);
                got_d.push_back(m_dout);
                if (first_wr < 0) first_wr = cyc;
            end
            if (m_done) begin
                done_cyc = cyc;
                busy_done = m_busy;
                break;
            end
            @(negedge a_clk);
            cyc++;
        end
        start4 = 1'b0;
        start32 = 1'b0;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_nwr"}, got_d.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_d.size(); i++) begin
            check($sformatf("%s_y%0d", tag, i), 32'(got_d[i]), 32'(exp_q[i]));
            check($sformatf("%s_a%0d", tag, i), 32'(got_a[i]), i);
        end
    endtask

    task automatic count_idle_writes(input int cycles);
        extra_wr = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge a_clk);
            if (d4_wr) extra_wr++;
        end
    endtask

    task automatic impulse_mem();
        h4[0] = 16'd1; h4[1] = 16'd2; h4[2] = 16'd3; h4[3] = 16'd4;
        for (int i = 0; i < 8; i++) x4[i] = 16'd0;
        x4[0] = 16'd1;
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) begin x4[i] = '0; x32[i] = '0; end
        for (int i = 0; i < 32; i++) h32[i] = '0;
        for (int i = 0; i < 4; i++) h4[i] = '0;
        sel = 1'b0; start4 = 1'b0; start32 = 1'b0; s_count = '0;
        a_rst_n = 1'b0;
        repeat (3) @(posedge a_clk);
        @(negedge a_clk);
        check("rst_ctl", {29'd0, d4_busy, d4_done, d4_wr}, 32'd0);
        check("rst_wa", 32'(d4_wa), 32'd0);
        check("rst_dout", 32'(d4_dout), 32'd0);
        check("rst_rd", {17'd0, d4_rd, d4_ca}, 32'd0);
        check("rst_state", 32'(d4_st), 32'(IDLE));
        a_rst_n = 1'b1;

        // Impulse response
        impulse_mem();
        run(1'b0, 6, 1'b0);
        exp_q = '{21'd1, 21'd2, 21'd3, 21'd4, 21'd0, 21'd0};
        check_writes("imp");
        check("imp_done", done_cyc, 49);
        check("imp_first_wr", first_wr, 8);
        check("imp_busy1", busy1, 1);
        check("imp_busy_done", busy_done, 0);

        // Step response
        h4[0] = 16'd1; h4[1] = 16'd1; h4[2] = 16'd1; h4[3] = 16'd1;
        for (int i = 0; i < 5; i++) x4[i] = 16'd100;
        run(1'b0, 5, 1'b0);
        exp_q = '{21'd100, 21'd200, 21'd300, 21'd400, 21'd400};
        check_writes("step");
        check("step_done", done_cyc, 41);

        // Positive and negative saturation
        for (int i = 0; i < 4; i++) begin h4[i] = 16'h7FFF; x4[i] = 16'h7FFF; end
        run(1'b0, 4, 1'b0);
        exp_q = '{21'h0FFFFF, 21'h0FFFFF, 21'h0FFFFF, 21'h0FFFFF};
        check_writes("satp");
        check("satp_done", done_cyc, 33);
        for (int i = 0; i < 4; i++) x4[i] = 16'h8000;
        run(1'b0, 4, 1'b0);
        exp_q = '{21'h100000, 21'h100000, 21'h100000, 21'h100000};
        check_writes("satn");

        // Empty run
        run(1'b0, 0, 1'b0);
        exp_q.delete();
        check_writes("cnt0");
        check("cnt0_done", done_cyc, 2);
        check("cnt0_busy1", busy1, 1);

        // Start held high across a 3-sample run
        impulse_mem();
        run(1'b0, 3, 1'b1);
        exp_q = '{21'd1, 21'd2, 21'd3};
        check_writes("hold");
        check("hold_done", done_cyc, 25);
        count_idle_writes(20);
        check("hold_extra_wr", extra_wr, 0);
        check("hold_busy_after", 32'(d4_busy), 32'd0);

        // Reset during MAC of n=1
        @(negedge a_clk);
        s_count = 14'd6;
        start4 = 1'b1;
        @(posedge a_clk);
        @(negedge a_clk);
        start4 = 1'b0;
        repeat (9) @(negedge a_clk);
        check("mid_state", 32'(d4_st), 32'(MAC));
        a_rst_n = 1'b0;
        @(posedge a_clk);
        @(negedge a_clk);
        check("mid_rst_ctl", {29'd0, d4_busy, d4_done, d4_wr}, 32'd0);
        check("mid_rst_wa", 32'(d4_wa), 32'd0);
        check("mid_rst_dout", 32'(d4_dout), 32'd0);
        check("mid_rst_rd", {17'd0, d4_rd, d4_ca}, 32'd0);
        a_rst_n = 1'b1;
        count_idle_writes(20);
        check("mid_extra_wr", extra_wr, 0);
        run(1'b0, 6, 1'b0);
        exp_q = '{21'd1, 21'd2, 21'd3, 21'd4, 21'd0, 21'd0};
        check_writes("imp2");
        check("imp2_done", done_cyc, 49);

        // Default parameters: 32 taps, shift 15
        h32[0] = 16'h4000;
        x32[0] = 16'h2000;
        x32[1] = 16'hE000;
        run(1'b1, 2, 1'b0);
        exp_q = '{21'h001000, 21'h1FF000};
        check_writes("def");
        check("def_done", done_cyc, 73);
        check("def_first_wr", first_wr, 36);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
